mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mul_seq.sv | 97 +++++++++
 tb/tb_mul_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// mul_seq: sequential shift-add multiplier, signed or unsigned, one multiplier bit per cycle.
// Ports: clk; rst (async, active-low); a_i/b_i operands and signed_i mode, sampled on an
// accepted start; busy while an operation runs; done pulses one cycle when result updates;
// result holds the 2*WIDTH-bit product until the next completion.
// Build option: define MUL_SEQ_EARLY_EXIT_EN to leave RUN once no multiplier bits remain.
module mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               signed_i,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   a_q, a_d, acc_q, acc_d, result_q, result_d;
    logic [WIDTH-1:0]     b_q, b_d, a_mag, b_mag;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d, done_q, done_d, a_neg, b_neg, last;
    // Magnitudes fit in WIDTH unsigned bits, including the signed minimum.
    assign a_neg = signed_i & a_i[WIDTH-1];
    assign b_neg = signed_i & b_i[WIDTH-1];
    assign a_mag = a_neg ? -a_i : a_i;
    assign b_mag = b_neg ? -b_i : b_i;
    // b_q shifts right each RUN cycle, so b_q[0] is multiplier bit[cnt_q] and
    // b_q[WIDTH-1:1] are the bits not yet processed.
`ifdef MUL_SEQ_EARLY_EXIT_EN
    assign last = (cnt_q == CW'(WIDTH-1)) || (b_q[WIDTH-1:1] == '0);
`else
    assign last = cnt_q == CW'(WIDTH-1);
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = last ? FIX : RUN;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;
        done_d   = 1'b0;
        if (state_q == IDLE && start) begin
            a_d   = {{WIDTH{1'b0}}, a_mag};
            b_d   = b_mag;
            neg_d = a_neg ^ b_neg;
            acc_d = '0;
            cnt_d = '0;
        end else if (state_q == RUN) begin
            acc_d = acc_q + (b_q[0] ? a_q : '0);
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CW'(1);
        end else if (state_q == FIX) begin
            // Negating a zero accumulator yields zero, so no negative zero exists.
            result_d = neg_q ? -acc_q : acc_q;
            done_d   = 1'b1;
        end
    end
    always_comb begin
        busy   = state_q != IDLE;
        done   = done_q;
        result = result_q;
    end
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed checks of mul_seq (WIDTH=8) for products, latency, busy, reset and back-to-back.
module tb_mul_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  a_i = '0, b_i = '0;
    logic        signed_i = 1'b0, start = 1'b0;
    logic        busy, done;
    logic [15:0] result;
    int          errors = 0, checks = 0;
`ifdef MUL_SEQ_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        bit          s;
        logic [15:0] p;
        int          ee;
    } vec_t;
    vec_t vecs[12];

    mul_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .a_i(a_i), .b_i(b_i), .signed_i(signed_i),
        .start(start), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts one operation and counts edges after the accepting edge until done.
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input bit s,
                           output int lat, output int bcnt);
        @(negedge clk);
        a_i = a; b_i = b; signed_i = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bcnt = busy ? 1 : 0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    initial begin
        int lat, bcnt, e, nd, exp1, exp2;
        int dedge[2];
        logic [15:0] dres[2];
        bit drop;
        vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 9};
        vecs[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000, 9};
        vecs[2]  = '{8'hFD, 8'h05, 1'b1, 16'hFFF1, 4};
        vecs[3]  = '{8'h07, 8'h01, 1'b0, 16'h0007, 2};
        vecs[4]  = '{8'h07, 8'h80, 1'b0, 16'h0380, 9};
        vecs[5]  = '{8'h00, 8'h00, 1'b0, 16'h0000, 2};
        vecs[6]  = '{8'hFD, 8'h00, 1'b1, 16'h0000, 2};
        vecs[7]  = '{8'h80, 8'h01, 1'b0, 16'h0080, 2};
        vecs[8]  = '{8'h7F, 8'hFF, 1'b1, 16'hFF81, 2};
        vecs[9]  = '{8'h0C, 8'h0A, 1'b0, 16'h0078, 5};
        vecs[10] = '{8'hFF, 8'hFF, 1'b1, 16'h0001, 2};
        vecs[11] = '{8'h80, 8'h7F, 1'b1, 16'hC080, 8};

        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_result", 32'(result), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        foreach (vecs[i]) begin
            run_mul(vecs[i].a, vecs[i].b, vecs[i].s, lat, bcnt);
            check($sformatf("prod%0d", i), 32'(result), 32'(vecs[i].p));
            check($sformatf("lat%0d", i), lat, EE ? vecs[i].ee : 9);
            check($sformatf("busy%0d", i), bcnt, EE ? vecs[i].ee : 9);
            check($sformatf("busy_at_done%0d", i), 32'(busy), 0);
        end

        // Start pulsed while busy must be ignored.
        @(negedge clk);
        a_i = 8'd5; b_i = 8'd5; signed_i = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_i = 8'd9; b_i = 8'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 3;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ignore_prod", 32'(result), 32'h0019);
        check("ignore_lat", lat, EE ? 4 : 9);
        repeat (12) @(posedge clk);
        #1;
        check("ignore_hold", 32'(result), 32'h0019);
        check("ignore_idle", 32'(busy), 0);

        // Reset mid-RUN clears outputs at once; no done follows.
        @(negedge clk);
        a_i = 8'd3; b_i = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(busy), 1);
        rst = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_result", 32'(result), 0);
        nd = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) nd++;
        end

        // Start held across reset release; back-to-back 6x7 then 2x3.
        a_i = 8'd6; b_i = 8'd7; start = 1'b1;
        @(negedge clk) rst = 1'b1;
        e = 0; drop = 0;
        dedge[0] = 0; dedge[1] = 0; dres[0] = '0; dres[1] = '0;
        while (e < 60 && dedge[1] == 0) begin
            @(posedge clk); #1;
            if (e == 0) begin a_i = 8'd2; b_i = 8'd3; end
            if (drop) begin start = 1'b0; drop = 0; end
            if (done) begin
                if (dedge[0] == 0) begin dedge[0] = e; dres[0] = result; drop = 1; end
                else begin dedge[1] = e; dres[1] = result; end
            end
            e++;
        end
        start = 1'b0;
        exp1 = EE ? 4 : 9;
        exp2 = EE ? 8 : 19;
        check("no_done_after_rst", nd, 0);
        check("b2b_edge1", dedge[0], exp1);
        check("b2b_prod1", 32'(dres[0]), 32'h002A);
        check("b2b_edge2", dedge[1], exp2);
        check("b2b_prod2", 32'(dres[1]), 32'h0006);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
